// File: rtl/die_mem_arbiter.sv
// die_mem_arbiter: round-robin arbiter granting NUM_CORES request channels
// onto one external memory bus. One transaction takes MEM_LAT+3 cycles:
// IDLE (grant) -> ISSUE (strobe) -> WAIT x MEM_LAT -> DONE (completion pulse).
//
// Ports:
//   clk, rst      die clock, synchronous active-high reset
//   req, we       per-channel request level and write enable
//   addr, wdata   per-channel operands, channel i at [i*W +: W]
//   done          one-hot completion pulse, one cycle long
//   rdata         read data shared by all channels, valid while done is high
//   mem_addr      memory address, held through ISSUE and WAIT
//   mem_wdata     write data for the pad, mem_oe enables the pad driver
//   mem_rdata     data sampled from the pad on the last WAIT cycle
//   mrd, mwr      one-cycle read / write strobes
module die_mem_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          mem_oe,
  output logic                          mrd,
  output logic                          mwr
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;

  logic              found;
  logic [IDX_W-1:0]  sel;
  int unsigned       cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // Round-robin search starting at ptr. Iterating downward lets the lowest
  // offset from ptr overwrite any later candidate, so no early exit is needed.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = 32'(ptr) + 32'(i);
      if (cand >= NUM_CORES) begin
        cand = cand - NUM_CORES;
      end
      if (req[IDX_W'(cand)]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  // Operands of the channel that would win this cycle.
  always_comb begin
    sel_addr  = addr[32'(sel) * ADDR_W +: ADDR_W];
    sel_wdata = wdata[32'(sel) * DATA_W +: DATA_W];
    sel_we    = we[sel];
  end

  // Transaction FSM; all bus outputs are registered and set on the edge
  // that enters the state in which they must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_oe    <= 1'b0;
      mrd       <= 1'b0;
      mwr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            win       <= sel;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_oe    <= sel_we;
            mrd       <= ~sel_we;
            mwr       <= sel_we;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mrd   <= 1'b0;
          mwr   <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            // Memory guarantees valid read data on the last WAIT cycle.
            if (!lat_we) begin
              rdata <= mem_rdata;
            end
            mem_oe <= 1'b0;
            done   <= ONE_HOT0 << win;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= '0;
          ptr   <= (win == LAST_IDX) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_die_mem_arbiter.sv
// Bench for die_mem_arbiter: a transaction-level model predicts every bus
// output from the grant cycle k of the in-flight transaction; a compare
// process checks the DUT each negedge, and directed tests pin the model
// with hand-computed literals.
module tb_die_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, done;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_oe, mrd, mwr;

  die_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_oe(mem_oe), .mrd(mrd), .mwr(mwr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Transaction-level model: one record for the in-flight access.
  bit           m_act = 0;
  bit           m_rst_seen = 0;
  bit           got;
  int           m_ptr = 0;
  int           m_ch = 0;
  int           m_k = 0;
  bit           m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_ptr = 0; m_rdata = '0; m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      if (m_act) begin
        if (ncyc == m_k + 1 + L && !m_we) m_rdata = mem_rdata;
        if (ncyc == m_k + 2 + L) begin
          m_ptr = (m_ch + 1) % N;
          m_act = 0;
        end
      end else if (req != '0) begin
        got = 0;
        for (int i = 0; i < N; i++) begin
          if (!got && req[(m_ptr + i) % N]) begin
            got = 1;
            m_ch = (m_ptr + i) % N;
          end
        end
        m_act  = 1;
        m_k    = ncyc;
        m_we   = we[m_ch];
        m_addr = addr[m_ch*AW +: AW];
        m_wd   = wdata[m_ch*DW +: DW];
      end
    end
  end

  // Compare process plus done log and strobe/oe counters for directed tests.
  int dch[$];
  int dcyc[$];
  int mrd_cnt = 0, mwr_cnt = 0, oe_cnt = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_done;
    bit e_mrd, e_mwr, e_oe, bus;
    if (m_rst_seen) begin
      check("rst_done", done, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_oe", mem_oe, 0);
      check("rst_mrd", mrd, 0);
      check("rst_mwr", mwr, 0);
    end else if (ncyc > 0) begin
      e_done = '0;
      if (m_act && ncyc == m_k + 2 + L) e_done[m_ch] = 1'b1;
      e_mrd = m_act && ncyc == m_k + 1 && !m_we;
      e_mwr = m_act && ncyc == m_k + 1 && m_we;
      bus   = m_act && ncyc >= m_k + 1 && ncyc <= m_k + 1 + L;
      e_oe  = bus && m_we;
      check("done", done, e_done);
      check("mrd", mrd, e_mrd);
      check("mwr", mwr, e_mwr);
      check("mem_oe", mem_oe, e_oe);
      check("rdata", rdata, m_rdata);
      if (bus) check("mem_addr", mem_addr, m_addr);
      if (e_oe) check("mem_wdata", mem_wdata, m_wd);
    end
    if (mrd) mrd_cnt++;
    if (mwr) mwr_cnt++;
    if (mem_oe) oe_cnt++;
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        dch.push_back(i);
        dcyc.push_back(ncyc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    mrd_cnt = 0; mwr_cnt = 0; oe_cnt = 0;
  endtask

  int k, nlog;
  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    cyc(3);
    rst = 1'b0;
    check("reset_done", done, 0);
    check("reset_rdata", rdata, 0);
    cyc(1);

    // 1: single read on channel 2
    addr[2*AW +: AW] = 32'h100;
    mem_rdata = 32'hDEADBEEF;
    clr_cnt(); nlog = dch.size(); k = ncyc;
    req = 4'b0100;
    cyc(1); req = '0;
    cyc(8);
    check("t1_ndone", dch.size() - nlog, 1);
    check("t1_ch", dch[$], 2);
    check("t1_latency", dcyc[$] - k, 4);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_mrd_cnt", mrd_cnt, 1);
    check("t1_oe_cnt", oe_cnt, 0);

    // 2: single write on channel 0, rdata must keep the old read value
    addr[0 +: AW] = 32'h20;
    wdata[0 +: DW] = 32'h55AA;
    we = 4'b0001;
    mem_rdata = 32'h12345678;
    clr_cnt(); nlog = dch.size();
    req = 4'b0001;
    cyc(1); req = '0;
    cyc(8);
    check("t2_ndone", dch.size() - nlog, 1);
    check("t2_ch", dch[$], 0);
    check("t2_mwr_cnt", mwr_cnt, 1);
    check("t2_mrd_cnt", mrd_cnt, 0);
    check("t2_oe_cnt", oe_cnt, 3);
    check("t2_rdata", rdata, 32'hDEADBEEF);

    // 3: round-robin with all channels requesting, from ptr = 0
    rst = 1'b1; cyc(1); rst = 1'b0;
    we = '0;
    mem_rdata = 32'hCAFE0000;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'h1000 * (i + 1);
    nlog = dch.size(); k = ncyc;
    req = 4'b1111;
    cyc(26); req = '0;
    cyc(8);
    check("t3_ndone", dch.size() - nlog, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_order%0d", i), dch[nlog + i], rr_exp[i]);
    check("t3_first", dcyc[nlog] - k, 4);
    for (int i = 1; i < 6; i++) check($sformatf("t3_gap%0d", i), dcyc[nlog + i] - dcyc[nlog + i - 1], 5);

    // 4: grant channel 2 (ptr -> 3), then 0101 wraps to 0 and then 2
    nlog = dch.size();
    req = 4'b0100;
    cyc(1); req = '0;
    cyc(6);
    req = 4'b0101;
    cyc(6); req = '0;
    cyc(8);
    check("t4_ndone", dch.size() - nlog, 3);
    check("t4_a", dch[nlog], 2);
    check("t4_b", dch[nlog + 1], 0);
    check("t4_c", dch[nlog + 2], 2);

    // 5: channel 1 read; req dropped in WAIT, operands changed after grant
    addr[1*AW +: AW] = 32'h300;
    mem_rdata = 32'hBBBB0001;
    clr_cnt(); nlog = dch.size();
    req = 4'b0010;
    cyc(1);
    addr[1*AW +: AW] = 32'h999;
    we = 4'b0010;
    cyc(1); req = '0;
    cyc(8);
    check("t5_ndone", dch.size() - nlog, 1);
    check("t5_ch", dch[$], 1);
    check("t5_rdata", rdata, 32'hBBBB0001);
    check("t5_mwr_cnt", mwr_cnt, 0);

    // 6: reset during WAIT of a read, then wrap search from ptr = 0
    we = '0;
    mem_rdata = 32'h77;
    nlog = dch.size();
    req = 4'b0001;
    cyc(1); req = '0;
    cyc(1); rst = 1'b1;
    cyc(1); rst = 1'b0;
    check("t6_mem_addr", mem_addr, 0);
    check("t6_rdata", rdata, 0);
    cyc(6);
    check("t6_no_done", dch.size() - nlog, 0);
    req = 4'b1000;
    cyc(1); req = '0;
    cyc(6);
    check("t6_ch3", dch[$], 3);
    check("t6_rdata2", rdata, 32'h77);
    req = 4'b1010;
    cyc(1); req = '0;
    cyc(6);
    check("t6_ch1", dch[$], 1);
    check("t6_ndone", dch.size() - nlog, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/die_mem_arbiter.md
# die_mem_arbiter

Parametrised multi-core memory-bus arbiter for the next-generation die. It replaces the single hard-wired core-to-memory connection with NUM_CORES independent request channels. Channels are granted round-robin onto the one external memory bus (mem_addr, mrd, mwr, data). It sits in the die top level between the SubCore instances and the die memory pins, and drives the output enable of the top-level bidirectional data pad.

## Interface
Parameters:
- NUM_CORES, 4: number of requesting channels (≥2).
- ADDR_W, 32: memory address width.
- DATA_W, 32: memory data width.
- MEM_LAT, 2: cycles from the mrd/mwr strobe to memory completion (≥1).

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  die clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_CORES  per-channel request level.
- we  in  NUM_CORES  per-channel write-enable (1 = write, 0 = read).
- addr  in  NUM_CORES*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  per-channel write data, same packing.
- done  out  NUM_CORES  one-cycle completion pulse, one-hot.
- rdata  out  DATA_W  read data, shared by all channels, valid while done is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  data driven onto the pad when mem_oe = 1.
- mem_rdata  in  DATA_W  data sampled from the pad.
- mem_oe  out  1  pad output enable.
- mrd  out  1  read strobe.
- mwr  out  1  write strobe.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Sample req. If no request is pending, stay in IDLE.
  - Otherwise pick the first channel with req = 1, searching upward from ptr and wrapping modulo NUM_CORES.
  - Latch the winner index, we, addr and wdata into internal registers, then go to ISSUE.
- **ISSUE** (1 cycle): assert mrd if the latched we = 0, otherwise assert mwr. Go to WAIT with the wait counter at 0.
- **WAIT** (MEM_LAT cycles): the counter increments each cycle. On the last WAIT cycle, register mem_rdata into rdata if the transaction is a read. Then go to DONE.
- **DONE** (1 cycle):
  - done[winner] = 1.
  - ptr = winner + 1, wrapping to 0 after NUM_CORES-1.
  - Go to IDLE.
- **Bus hold:** mem_addr shows the latched address throughout ISSUE and WAIT.
- **Writes:** mem_wdata shows the latched data and mem_oe = 1 throughout ISSUE and WAIT.
- **Fixed values:** mem_oe = 0 in IDLE and DONE. For writes, rdata keeps its previous value.
- **Request sampling:** req is sampled only in IDLE.
  - Deasserting req after the grant does not abort; the transaction completes and done still pulses.
  - req still high in the IDLE cycle after DONE counts as a new request.
- **Operand stability:** changes to addr, wdata or we after the grant are ignored, because the operands are latched.

## Timing
- Reset values: state = IDLE, ptr = 0, done = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_oe = 0, mrd = 0, mwr = 0.
- Let k be the IDLE cycle in which the grant is sampled:
  - ISSUE occurs in cycle k+1; mrd or mwr is high only in this cycle.
  - WAIT occurs in cycles k+2 through k+1+MEM_LAT.
  - done is high in cycle k+2+MEM_LAT.
  - The next grant can be sampled in cycle k+3+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles.
- Read latency: req sampled to done is MEM_LAT+2 cycles.
- Memory contract: memory must drive mem_rdata valid during the last WAIT cycle.
- Strobes: mrd and mwr are never high together, and at most one strobe fires per transaction.
- done is never multi-hot and is never asserted outside DONE.
- Reset mid-transaction: all outputs return to reset values on the next edge, the in-flight access is dropped, no done pulse is issued, and ptr = 0.
- Fairness: with all NUM_CORES channels continuously requesting, every channel receives exactly one grant in every NUM_CORES consecutive transactions.

## Test plan
Configuration: NUM_CORES = 4, MEM_LAT = 2.
1. **Single read:** after reset, req = 0100, we = 0, addr[2] = 0x100, memory returns 0xDEADBEEF. Required: mrd high exactly 1 cycle with mem_addr = 0x100, then done = 0100 four cycles after the sampling edge with rdata = 0xDEADBEEF. mem_oe stays 0 throughout.
2. **Single write:** req = 0001, we = 0001, addr[0] = 0x20, wdata[0] = 0x55AA. Required: mwr pulses once; mem_oe = 1 and mem_wdata = 0x55AA for 3 cycles (ISSUE and WAIT); done = 0001; rdata unchanged.
3. **Round-robin:** req = 1111 held continuously. Required: grant order 0, 1, 2, 3, 0, 1, with done pulses spaced 5 cycles apart.
4. **Wrap and skip:** ptr = 3 after a channel 2 grant; req = 0101. Required: channel 0 wins, then channel 2.
5. **Request dropped:** channel 1 is granted and deasserts req during WAIT. Required: the transaction completes and done[1] still pulses.
6. **Reset mid-op:** rst asserted during WAIT of a read. Required: next cycle, all outputs are 0 and there is no done pulse; afterwards, req = 1000 is granted channel 3 first, confirming ptr = 0 and a correct wrap search.
